muxn_pipe: RTL and testbench
============================

Name: muxn_pipe

Overview:
- Parametrised, pipelined N:1 word multiplexer. Next generation of the team's combinational radix-2 mux tree.
- Adds the following over the combinational tree:
  - non-power-of-2 port counts;
  - configurable register insertion between tree levels;
  - valid/ready flow control with backpressure;
  - out-of-range select detection.
- Sits between multi-port flop-array read banks and a single consumer; replaces the combinational tree where read paths fail timing.

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- PRT, 32, number of input ports (>=2, need not be a power of 2)
- PIPE_EVERY, 1, register stage after every PIPE_EVERY tree levels (>=1)
- BITPRT, $clog2(PRT), select width (derived; do not override)
- NSTG, ceil(BITPRT/PIPE_EVERY), pipeline depth = latency in cycles (derived)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_vld  input  1  input word set and select valid
- in_rdy  output  1  block can accept input this cycle
- sel  input  BITPRT  port select; values >= PRT are out of range
- x  input  PRT*WIDTH  flattened inputs, port i at bits [(i+1)*WIDTH-1 : i*WIDTH]
- out_vld  output  1  y valid
- out_rdy  input  1  consumer accepts y
- y  output  WIDTH  selected word
- sel_err  output  1  qualifies y: the select for this word was out of range

Behaviour:
- Tree structure:
  - Level lv (0..BITPRT-1) has ceil(PRT/2^(lv+1)) mux2 nodes, steered by sel bit lv.
  - A node with a missing b-leg passes its a-leg when the sel bit is 0 and drives 0 when it is 1.
- Pipeline registers:
  - A register stage follows level lv when (lv+1)%PIPE_EVERY==0, or when lv==BITPRT-1.
  - Each stage registers the partial results, the remaining upper sel bits, a valid bit and an err bit.
- Out-of-range select:
  - err = (sel >= PRT), computed at input and carried down the pipe.
  - When err is set, y is forced to 0 at the output stage.
- Latency: exactly NSTG cycles from the accepted input (in_vld && in_rdy) to out_vld, with no stall.
- Flow control:
  - stall = out_vld && !out_rdy; in_rdy = !stall.
  - On stall, all stages hold: data, sel, valid and err are frozen.
  - Otherwise every stage advances by one and bubbles are allowed: stage valid = upstream valid.
- Output hold:
  - Data/sel/err registers load only when the incoming valid is 1 and the pipe is not stalled.
  - y and sel_err therefore hold their last values while out_vld=0.
- Reset (rst_n=0 at a clock edge):
  - All valid bits clear; data, sel and err registers clear.
  - y=0, sel_err=0, out_vld=0; in_rdy=1 on the first cycle after reset.
- Reset mid-operation discards in-flight words; no output is produced for them.
- Simultaneous events:
  - Input acceptance and output drain in the same cycle are legal; full throughput is 1 word/cycle.
  - When out_rdy falls while the pipe is full, no word is lost or duplicated.
- Protocol rule: x and sel are sampled only when in_vld && in_rdy; other values are don't-care.

Test Plan:
- WIDTH=8, PRT=5, PIPE_EVERY=1 (NSTG=3); x={p4=0x44,p3=0x33,p2=0x22,p1=0x11,p0=0x00}; sel=2 for one cycle with out_rdy=1 -> out_vld=1 exactly 3 cycles later, y=0x22, sel_err=0.
- Same configuration, sel=0..4 streamed back-to-back -> y=0x00,0x11,0x22,0x33,0x44 on 5 consecutive cycles; in_rdy held 1 throughout.
- Same configuration, sel=6 -> y=0x00 and sel_err=1 after 3 cycles; the next word (sel=4) gives y=0x44, sel_err=0.
- Backpressure: stream sel=1,2,3 and hold out_rdy=0 for 4 cycles once out_vld rises:
  - in_rdy=0 while stalled and y stays 0x11;
  - after release, 0x11,0x22,0x33 appear in order with no loss or duplicate.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 words in flight -> next cycle out_vld=0, y=0, in_rdy=1; no stale word emerges later.
- PIPE_EVERY=2, PRT=32 (NSTG=3); random sel/x over 1000 transactions with random out_rdy -> output sequence matches a reference queue, and latency is 3 when unstalled.

Source files
------------

// File: rtl/muxn_pipe.sv
// Pipelined N:1 word multiplexer: radix-2 mux tree with optional registers
// between levels, valid/ready backpressure and out-of-range select flagging.
module muxn_pipe #(
  parameter int WIDTH      = 32,
  parameter int PRT        = 32,
  parameter int PIPE_EVERY = 1,
  parameter int BITPRT     = $clog2(PRT),
  parameter int NSTG       = (BITPRT + PIPE_EVERY - 1) / PIPE_EVERY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [BITPRT-1:0]    sel,
  input  logic [PRT*WIDTH-1:0] x,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH-1:0]     y,
  output logic                 sel_err
);

  typedef logic [PRT-1:0][WIDTH-1:0] words_t;

  // Boundary signals between tree levels; index 0 is the block input,
  // index BITPRT is the output of the last (always registered) level.
  words_t            lvl_data [BITPRT+1];
  logic [BITPRT-1:0] lvl_sel  [BITPRT+1];
  logic              lvl_vld  [BITPRT+1];
  logic              lvl_err  [BITPRT+1];
  logic              stall;

  // A single global stall freezes every stage, so no per-stage skid is needed.
  assign stall  = out_vld && !out_rdy;
  assign in_rdy = !stall;

  assign lvl_data[0] = x;
  assign lvl_sel[0]  = sel;
  assign lvl_vld[0]  = in_vld;
  assign lvl_err[0]  = int'(sel) >= PRT;

  for (genvar lv = 0; lv < BITPRT; lv++) begin : g_lvl
    localparam int NIN     = (PRT + (1 << lv) - 1) >> lv;
    localparam int NOUT    = (NIN + 1) / 2;
    localparam bit HAS_REG = ((lv + 1) % PIPE_EVERY == 0) || (lv == BITPRT - 1);

    words_t mux_d;

    always_comb begin
      // NOTE: default every word first so unused slots never infer a latch.
      mux_d = '0;
      for (int k = 0; k < NOUT; k++) begin
        if (lvl_sel[lv][lv]) begin
          // A node without a b-leg yields 0 when the b side is selected.
          mux_d[k] = (2 * k + 1 < NIN) ? lvl_data[lv][(2 * k + 1 < NIN) ? 2 * k + 1 : 2 * k]
                                       : '0;
        end else begin
          mux_d[k] = lvl_data[lv][2 * k];
        end
      end
    end

    if (HAS_REG) begin : g_reg
      words_t            data_q;
      logic [BITPRT-1:0] sel_q;
      logic              vld_q;
      logic              err_q;

      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // stage samples its upstream value from before this edge.
        if (!rst_n) begin
          // NOTE: data registers are reset too, so y reads 0 straight out of reset.
          data_q <= '0;
          sel_q  <= '0;
          vld_q  <= 1'b0;
          err_q  <= 1'b0;
        end else if (!stall) begin
          vld_q <= lvl_vld[lv];
          if (lvl_vld[lv]) begin
            data_q <= mux_d;
            sel_q  <= lvl_sel[lv];
            err_q  <= lvl_err[lv];
          end
        end
      end

      assign lvl_data[lv+1] = data_q;
      assign lvl_sel[lv+1]  = sel_q;
      assign lvl_vld[lv+1]  = vld_q;
      assign lvl_err[lv+1]  = err_q;
    end else begin : g_comb
      assign lvl_data[lv+1] = mux_d;
      assign lvl_sel[lv+1]  = lvl_sel[lv];
      assign lvl_vld[lv+1]  = lvl_vld[lv];
      assign lvl_err[lv+1]  = lvl_err[lv];
    end
  end

  // Output fields come straight from the last stage, so they hold while idle.
  assign out_vld = lvl_vld[BITPRT];
  assign sel_err = lvl_err[BITPRT];
  assign y       = lvl_err[BITPRT] ? '0 : lvl_data[BITPRT][0];

endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench: directed scenarios on a 5-port pipe plus a randomized
// 32-port, two-levels-per-stage pipe checked against a reference queue.
module tb_muxn_pipe;

  localparam int AW = 8;
  localparam int AP = 5;
  localparam int AB = 3;
  localparam int BW = 16;
  localparam int BP = 32;
  localparam int BB = 5;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_sel_err;
  logic [AB-1:0]     a_sel;
  logic [AP*AW-1:0]  a_x;
  logic [AW-1:0]     a_y;
  logic              b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_sel_err;
  logic [BB-1:0]     b_sel;
  logic [BP*BW-1:0]  b_x;
  logic [BW-1:0]     b_y;

  int total = 0;
  int bad   = 0;

  muxn_pipe #(.WIDTH(AW), .PRT(AP), .PIPE_EVERY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .sel(a_sel),
    .x(a_x), .out_vld(a_out_vld), .out_rdy(a_out_rdy), .y(a_y), .sel_err(a_sel_err)
  );

  muxn_pipe #(.WIDTH(BW), .PRT(BP), .PIPE_EVERY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .sel(b_sel),
    .x(b_x), .out_vld(b_out_vld), .out_rdy(b_out_rdy), .y(b_y), .sel_err(b_sel_err)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (a_out_vld !== 1'b0) begin bad++; $display("FAIL reset_a_out_vld got=%b exp=0", a_out_vld); end
    total++; if (a_y !== 8'h00) begin bad++; $display("FAIL reset_a_y got=%h exp=00", a_y); end
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL reset_a_sel_err got=%b exp=0", a_sel_err); end
    total++; if (a_in_rdy !== 1'b1) begin bad++; $display("FAIL reset_a_in_rdy got=%b exp=1", a_in_rdy); end
    total++; if (b_out_vld !== 1'b0) begin bad++; $display("FAIL reset_b_out_vld got=%b exp=0", b_out_vld); end
    total++; if (b_in_rdy !== 1'b1) begin bad++; $display("FAIL reset_b_in_rdy got=%b exp=1", b_in_rdy); end
  endtask

  task automatic test_single();
    @(negedge clk);
    a_sel = 3'd2; a_in_vld = 1'b1; a_out_rdy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      a_in_vld = 1'b0;
      #1;
      total++;
      if (a_out_vld !== (c == LAT)) begin
        bad++; $display("FAIL single_out_vld cycle=%0d got=%b exp=%b", c, a_out_vld, (c == LAT));
      end
      if (c == LAT) begin
        total++; if (a_y !== 8'h22) begin bad++; $display("FAIL single_y got=%h exp=22", a_y); end
        total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL single_sel_err got=%b exp=0", a_sel_err); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] got_y[$];
    int            got_c[$];
    @(negedge clk);
    a_sel = 3'd0; a_in_vld = 1'b1; a_out_rdy = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c < 5) a_sel = AB'(c);
      else       a_in_vld = 1'b0;
      #1;
      if (c < 5) begin
        total++; if (a_in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_in_rdy cycle=%0d got=%b exp=1", c, a_in_rdy); end
      end
      if (a_out_vld) begin got_y.push_back(a_y); got_c.push_back(c); end
    end
    total++;
    if (got_y.size() != 5) begin
      bad++; $display("FAIL b2b_count got=%0d exp=5", got_y.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (got_y[k] !== AW'(k * 8'h11)) begin bad++; $display("FAIL b2b_y idx=%0d got=%h exp=%h", k, got_y[k], AW'(k * 8'h11)); end
        total++;
        if (got_c[k] != LAT + k) begin bad++; $display("FAIL b2b_cycle idx=%0d got=%0d exp=%0d", k, got_c[k], LAT + k); end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] got_y[$];
    logic          got_e[$];
    @(negedge clk);
    a_sel = 3'd6; a_in_vld = 1'b1; a_out_rdy = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) a_sel = 3'd4;
      else        a_in_vld = 1'b0;
      #1;
      if (a_out_vld) begin got_y.push_back(a_y); got_e.push_back(a_sel_err); end
    end
    total++;
    if (got_y.size() != 2) begin
      bad++; $display("FAIL oor_count got=%0d exp=2", got_y.size());
    end else begin
      total++; if (got_y[0] !== 8'h00) begin bad++; $display("FAIL oor_y got=%h exp=00", got_y[0]); end
      total++; if (got_e[0] !== 1'b1) begin bad++; $display("FAIL oor_sel_err got=%b exp=1", got_e[0]); end
      total++; if (got_y[1] !== 8'h44) begin bad++; $display("FAIL oor_next_y got=%h exp=44", got_y[1]); end
      total++; if (got_e[1] !== 1'b0) begin bad++; $display("FAIL oor_next_sel_err got=%b exp=0", got_e[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] got_y[$];
    @(negedge clk);
    a_sel = 3'd1; a_in_vld = 1'b1; a_out_rdy = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) a_sel = 3'd2;
      if (c == 2) a_sel = 3'd3;
      if (c == 3) begin a_in_vld = 1'b0; a_out_rdy = 1'b0; end
      if (c == 7) a_out_rdy = 1'b1;
      #1;
      if (c >= 3 && c <= 6) begin
        total++; if (a_in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy cycle=%0d got=%b exp=0", c, a_in_rdy); end
        total++; if (a_out_vld !== 1'b1) begin bad++; $display("FAIL bp_out_vld cycle=%0d got=%b exp=1", c, a_out_vld); end
        total++; if (a_y !== 8'h11) begin bad++; $display("FAIL bp_hold_y cycle=%0d got=%h exp=11", c, a_y); end
      end
      if (c == 12) begin
        total++; if (a_out_vld !== 1'b0) begin bad++; $display("FAIL bp_idle_vld got=%b exp=0", a_out_vld); end
        total++; if (a_y !== 8'h33) begin bad++; $display("FAIL bp_idle_y_hold got=%h exp=33", a_y); end
      end
      if (a_out_vld && a_out_rdy) got_y.push_back(a_y);
    end
    total++;
    if (got_y.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d exp=3", got_y.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (got_y[k] !== AW'((k + 1) * 8'h11)) begin bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", k, got_y[k], AW'((k + 1) * 8'h11)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_sel = 3'd1; a_in_vld = 1'b1; a_out_rdy = 1'b1;
    @(negedge clk);
    a_sel = 3'd2;
    @(negedge clk);
    a_in_vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (a_out_vld !== 1'b0) begin bad++; $display("FAIL rstmid_out_vld got=%b exp=0", a_out_vld); end
    total++; if (a_y !== 8'h00) begin bad++; $display("FAIL rstmid_y got=%h exp=00", a_y); end
    total++; if (a_in_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_in_rdy got=%b exp=1", a_in_rdy); end
    total++; if (a_sel_err !== 1'b0) begin bad++; $display("FAIL rstmid_sel_err got=%b exp=0", a_sel_err); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      total++; if (a_out_vld !== 1'b0) begin bad++; $display("FAIL rstmid_stale cycle=%0d got=%b exp=0", c, a_out_vld); end
    end
  endtask

  typedef struct {
    logic [BW-1:0] y;
    int            cyc;
    int            stalls;
  } exp_t;

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   sent = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   lat;
    logic exp_rdy;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      b_out_rdy = ($urandom_range(0, 3) != 0);
      if (sent < 1000 && $urandom_range(0, 4) != 0) begin
        b_in_vld = 1'b1;
        b_sel = BB'($urandom);
        for (int i = 0; i < BP; i++) b_x[i*BW +: BW] = BW'($urandom);
      end else begin
        b_in_vld = 1'b0;
      end
      #1;
      exp_rdy = !(b_out_vld && !b_out_rdy);
      total++;
      if (b_in_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_in_rdy cycle=%0d got=%b exp=%b", cyc, b_in_rdy, exp_rdy); end
      if (b_out_vld && b_out_rdy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious cycle=%0d y=%h exp=no output", cyc, b_y);
        end else begin
          e = q.pop_front();
          if (b_y !== e.y || b_sel_err !== 1'b0) begin
            bad++; $display("FAIL rnd_data cycle=%0d got=%h/%b exp=%h/0", cyc, b_y, b_sel_err, e.y);
          end
          lat = cyc - e.cyc - (stall_cnt - e.stalls);
          total++;
          if (lat != LAT) begin bad++; $display("FAIL rnd_latency cycle=%0d got=%0d exp=%0d", cyc, lat, LAT); end
        end
      end
      if (b_in_vld && exp_rdy) begin
        e.y = b_x[b_sel*BW +: BW];
        e.cyc = cyc;
        e.stalls = stall_cnt;
        q.push_back(e);
        sent++;
      end
      if (!exp_rdy) stall_cnt++;
      cyc++;
    end
    b_in_vld = 1'b0;
    total++;
    if (cyc >= 20000) begin bad++; $display("FAIL rnd_timeout sent=%0d pending=%0d exp=all drained", sent, q.size()); end
  endtask

  initial begin
    a_in_vld = 1'b0; a_out_rdy = 1'b1; a_sel = '0;
    a_x = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    b_in_vld = 1'b0; b_out_rdy = 1'b1; b_sel = '0; b_x = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
